// File: rtl/cordic_arcsine_arbiter.sv
// cordic_arcsine_arbiter: round-robin two-requester front end for a shared CORDIC arcsine engine with per-job timeout.
// Ports: clk/rst (sync, active-high); req_valid/req_z0/req_z1 in, req_ready accept pulse out;
// rsp_valid/rsp_result/rsp_error/rsp_timeout response out; eng_start/eng_z to engine;
// eng_result/eng_done/eng_error from engine; busy high outside IDLE.
module cordic_arcsine_arbiter #(
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req_valid,
  input  logic [15:0] req_z0,
  input  logic [15:0] req_z1,
  output logic [1:0]  req_ready,
  output logic [1:0]  rsp_valid,
  output logic [15:0] rsp_result,
  output logic        rsp_error,
  output logic        rsp_timeout,
  output logic        eng_start,
  output logic [15:0] eng_z,
  input  logic [15:0] eng_result,
  input  logic        eng_done,
  input  logic        eng_error,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  localparam logic [7:0] TLIM = 8'(TIMEOUT - 1);
  state_t      state_q;
  logic        last_q, g_q, error_q, timeout_q, g;
  logic [7:0]  timer_q, timer_d;
  logic [15:0] z_q, result_q;
  // Both pending: the requester not served last wins; otherwise the lone requester.
  assign g         = &req_valid ? ~last_q : req_valid[1];
  assign timer_d   = timer_q + 8'd1;
  assign req_ready = (state_q == IDLE && !rst && |req_valid) ? (g ? 2'b10 : 2'b01) : 2'b00;
  assign rsp_valid = (state_q == RESP) ? (g_q ? 2'b10 : 2'b01) : 2'b00;
  assign eng_start = state_q == ISSUE;
  assign busy      = state_q != IDLE;
  assign eng_z     = z_q;
  assign rsp_result  = result_q;
  assign rsp_error   = error_q;
  assign rsp_timeout = timeout_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      last_q    <= 1'b1;
      g_q       <= 1'b0;
      timer_q   <= '0;
      z_q       <= '0;
      result_q  <= '0;
      error_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (|req_valid) begin
          g_q     <= g;
          z_q     <= g ? req_z1 : req_z0;
          state_q <= ISSUE;
        end
        ISSUE: begin
          timer_q <= '0;
          state_q <= WAIT;
        end
        WAIT: begin
          timer_q <= timer_d;
          // A completion flag beats a timer expiry landing in the same cycle.
          if (eng_done || eng_error) begin
            result_q  <= eng_result;
            error_q   <= eng_error;
            timeout_q <= 1'b0;
            state_q   <= RESP;
          end else if (timer_d == TLIM) begin
            result_q  <= '0;
            error_q   <= 1'b1;
            timeout_q <= 1'b1;
            state_q   <= RESP;
          end
        end
        RESP: begin
          last_q  <= g_q;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule
